hwag_cfg_seq: RTL

- Bus sequencer and arbiter in front of the hwag ssram register port.
- After reset, or on a start pulse, it replays an external init table of (addr, data) pairs into hwag: filter, tooth count HWATHNB, HWACR0, interrupt enables, HWATHVL.
- Once the table is done, it grants the register port to a host requester, one transaction at a time.
- Owns ssram_we/ssram_re/ssram_addr and the data output enable, so hwag never sees overlapping accesses.

---
 rtl/hwag_cfg_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hwag_cfg_seq.sv
// hwag_cfg_seq: replays an (addr, data) init table into the hwag ssram register port, then arbitrates host accesses.
// Optional readback check of every boot write: define HWAG_CFG_VERIFY_EN.
module hwag_cfg_seq #(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int TBL_AW = 6,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              auto_start,
    output logic [TBL_AW-1:0] tbl_idx,
    input  logic [AW-1:0]     tbl_addr,
    input  logic [DW-1:0]     tbl_data,
    input  logic              tbl_last,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [AW-1:0]     host_addr,
    input  logic [DW-1:0]     host_wdata,
    output logic              host_ack,
    output logic [DW-1:0]     host_rdata,
    output logic              ssram_we,
    output logic              ssram_re,
    output logic [AW-1:0]     ssram_addr,
    output logic [DW-1:0]     ssram_wdata,
    output logic              ssram_oe,
    input  logic [DW-1:0]     ssram_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, BOOT_WR, BOOT_NEXT, BOOT_RD, BOOT_CMP, READY, H_WR, H_RD
    } state_t;

    localparam logic [2:0] RD_LAST = 3'(RD_LAT);
    localparam logic [2:0] RD_ACK  = 3'(RD_LAT + 1);

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       first_cyc;
    logic       boot_go;
    logic       tbl_end;

    // The arm flag is auto_start as seen on the first clock after reset.
    assign boot_go = (state == IDLE) ? (start | (first_cyc & auto_start)) : start;
    assign tbl_end = tbl_last | (&tbl_idx);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (boot_go) state_nxt = BOOT_WR;
`ifdef HWAG_CFG_VERIFY_EN
            BOOT_WR:   state_nxt = BOOT_RD;
            BOOT_RD:   if (cnt == RD_LAST) state_nxt = BOOT_CMP;
            BOOT_CMP:  state_nxt = (ssram_rdata != tbl_data) ? IDLE : BOOT_NEXT;
`else
            BOOT_WR:   state_nxt = BOOT_NEXT;
`endif
            BOOT_NEXT: state_nxt = tbl_end ? READY : BOOT_WR;
            READY: begin
                if (boot_go)
                    state_nxt = BOOT_WR;
                else if (host_req)
                    state_nxt = host_we ? H_WR : H_RD;
            end
            H_WR:      state_nxt = READY;
            H_RD:      if (cnt == RD_ACK) state_nxt = READY;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            first_cyc  <= 1'b1;
            tbl_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            host_rdata <= '0;
`ifdef HWAG_CFG_VERIFY_EN
            err        <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            first_cyc <= 1'b0;
            cnt       <= (state_nxt == state) ? cnt + 3'd1 : 3'd0;

            if ((state == IDLE || state == READY) && state_nxt == BOOT_WR) begin
                busy    <= 1'b1;
                done    <= 1'b0;
                tbl_idx <= '0;
`ifdef HWAG_CFG_VERIFY_EN
                err     <= 1'b0;
`endif
            end

            if (state == BOOT_NEXT) begin
                if (tbl_end) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    tbl_idx <= tbl_idx + TBL_AW'(1);
                end
            end

`ifdef HWAG_CFG_VERIFY_EN
            // Failed readback parks in IDLE with the arm flag gone; only start recovers.
            if (state == BOOT_CMP && state_nxt == IDLE) begin
                err  <= 1'b1;
                busy <= 1'b0;
                done <= 1'b0;
            end
`endif

            if (state == H_RD && cnt == RD_LAST)
                host_rdata <= ssram_rdata;
        end
    end

`ifndef HWAG_CFG_VERIFY_EN
    assign err = 1'b0;
`endif

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        ssram_we    = 1'b0;
        ssram_re    = 1'b0;
        ssram_oe    = 1'b0;
        ssram_addr  = '0;
        ssram_wdata = '0;
        host_ack    = 1'b0;
        case (state)
            BOOT_WR: begin
                ssram_we    = 1'b1;
                ssram_oe    = 1'b1;
                ssram_addr  = tbl_addr;
                ssram_wdata = tbl_data;
            end
`ifdef HWAG_CFG_VERIFY_EN
            BOOT_RD: begin
                ssram_addr = tbl_addr;
                ssram_re   = (cnt == 3'd1);
            end
            BOOT_CMP: ssram_addr = tbl_addr;
`endif
            H_WR: begin
                ssram_we    = 1'b1;
                ssram_oe    = 1'b1;
                ssram_addr  = host_addr;
                ssram_wdata = host_wdata;
                host_ack    = 1'b1;
            end
            H_RD: begin
                ssram_addr = host_addr;
                ssram_re   = (cnt == 3'd0);
                host_ack   = (cnt == RD_ACK);
            end
            default: ;
        endcase
    end

endmodule
